// File: rtl/signeddiv_seq_12.sv
// Iterative signed fixed-point divider, c = a / b.
// Operands and result are W-bit two's complement with FRAC fractional bits.
// The divider works on magnitudes with restoring division, one quotient bit per
// cycle, then applies the sign and saturates. A division by zero still runs all
// the steps so that latency is always the same.
module signeddiv_seq_12 #(
  parameter int unsigned FRAC = 12,
  parameter int unsigned W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] c,
  output logic         ovf,
  output logic         dz
);

  // Dividend width: |a| followed by FRAC zero bits.
  localparam int unsigned DW = W + FRAC;
  localparam int unsigned CW = $clog2(DW);

  // Largest quotient magnitudes that still fit for each result sign.
  localparam logic [DW-1:0] QPosMax = DW'((2 ** (W - 1)) - 1);
  localparam logic [DW-1:0] QNegMax = DW'(2 ** (W - 1));
  localparam logic [W-1:0]  CPosSat = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]  CNegSat = {1'b1, {(W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [DW-1:0]   dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    c_q, c_d;
  logic            ovf_q, ovf_d;
  logic            dz_q, dz_d;

  // Operand magnitudes; the most negative input maps to 2**(W-1) unsigned.
  logic [W-1:0] abs_a;
  logic [W-1:0] abs_b;

  // Restoring-step datapath.
  logic [W:0]   rem_shift;
  logic         fits;
  logic [W-1:0] rem_diff;
  logic [W-1:0] quot_neg;

  // Magnitudes of the incoming operands.
  always_comb begin
    abs_a = a[W-1] ? (~a + W'(1)) : a;
    abs_b = b[W-1] ? (~b + W'(1)) : b;
  end

  // One restoring step: bring down the next dividend bit and trial-subtract.
  always_comb begin
    rem_shift = {rem_q, dvd_q[DW-1]};
    fits      = (rem_shift >= {1'b0, dvs_q});
    // When the subtraction is taken the difference is below the divisor, so W bits suffice.
    rem_diff  = rem_shift[W-1:0] - dvs_q;
    quot_neg  = W'(0) - quot_q[W-1:0];
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_d     = c_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = a[W-1] ^ b[W-1];
          dvd_d   = {abs_a, {FRAC{1'b0}}};
          dvs_d   = abs_b;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end

      StRun: begin
        rem_d  = fits ? rem_diff : rem_shift[W-1:0];
        quot_d = {quot_q[DW-2:0], fits};
        dvd_d  = {dvd_q[DW-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_d = StFin;
        end
      end

      StFin: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
        if (dvs_q == '0) begin
          dz_d  = 1'b1;
          ovf_d = 1'b0;
          c_d   = sign_q ? CNegSat : CPosSat;
        end else begin
          dz_d = 1'b0;
          if (!sign_q) begin
            if (quot_q > QPosMax) begin
              c_d   = CPosSat;
              ovf_d = 1'b1;
            end else begin
              c_d   = quot_q[W-1:0];
              ovf_d = 1'b0;
            end
          end else begin
            if (quot_q > QNegMax) begin
              c_d   = CNegSat;
              ovf_d = 1'b1;
            end else begin
              // Negating zero yields zero, so a zero quotient never turns negative.
              c_d   = quot_neg;
              ovf_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sign_q  <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    busy = busy_q;
    done = done_q;
    c    = c_q;
    ovf  = ovf_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_signeddiv_seq_12.sv
// Directed self-checking bench for signeddiv_seq_12 with an expected-result queue.
module tb_signeddiv_seq_12;

  typedef struct packed {
    logic [15:0] c;
    logic        ovf;
    logic        dz;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] c;
  logic        ovf;
  logic        dz;

  int   n_checks = 0;
  int   n_fails = 0;
  bit   overlap = 1'b0;
  res_t exp_q[$];

  signeddiv_seq_12 #(.FRAC(12), .W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c),
    .ovf  (ovf),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  // busy and done must never be high together.
  always @(negedge clk) if (busy && done) overlap = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer division on real values, then clamp to range.
  function automatic res_t model(input logic [15:0] av, input logic [15:0] bv);
    int   sa, sb, q, r;
    logic [31:0] rv;
    res_t e;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sb == 0) begin
      e.dz  = 1'b1;
      e.ovf = 1'b0;
      e.c   = (av[15] ^ bv[15]) ? 16'h8000 : 16'h7FFF;
    end else begin
      q = ((sa < 0 ? -sa : sa) * 4096) / (sb < 0 ? -sb : sb);
      r = (av[15] ^ bv[15]) ? -q : q;
      e.dz = 1'b0;
      if (r > 32767) begin
        e.c = 16'h7FFF; e.ovf = 1'b1;
      end else if (r < -32768) begin
        e.c = 16'h8000; e.ovf = 1'b1;
      end else begin
        rv = r; e.c = rv[15:0]; e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  // Drive one start pulse; expected result is queued at the accept edge.
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input bit push);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back(model(av, bv));
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  // Wait for done (bounded), check latency/busy, then pop and compare.
  task automatic wait_result(input string tag, input bit pulse);
    int   k;
    int   busy_n;
    res_t e;
    k = 0;
    busy_n = 0;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (done) break;
      if (busy) busy_n++;
      if (k == 3) begin a = 16'h5A5A; b = 16'h0123; end
      if (pulse && k == 10) begin start = 1'b1; a = 16'h1234; b = 16'h0003; end
      if (pulse && k == 11) start = 1'b0;
    end
    chk({tag, "_latency"}, k, 32'd29);
    chk({tag, "_busy_cycles"}, busy_n, 32'd28);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_queue_nonempty"}, {31'b0, exp_q.size() > 0}, 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_c"}, {16'b0, c}, {16'b0, e.c});
      chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
      chk({tag, "_dz"}, {31'b0, dz}, {31'b0, e.dz});
    end
  endtask

  // Count done pulses over a window where none should appear.
  task automatic expect_quiet(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    chk(tag, n, 32'd0);
  endtask

  initial begin
    // Reset state, both during and after reset.
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_c", {16'b0, c}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_c", {16'b0, c}, 32'd0);

    // Basic, fractional truncation, signs.
    accept(16'h3000, 16'h1000, 1'b1); wait_result("three_by_one", 1'b0);
    accept(16'h1000, 16'h3000, 1'b1); wait_result("third", 1'b0);
    accept(16'hE000, 16'h0800, 1'b1); wait_result("neg_two_by_half", 1'b0);
    accept(16'hF000, 16'hF000, 1'b1); wait_result("neg_by_neg", 1'b0);
    accept(16'hF000, 16'h3000, 1'b1); wait_result("neg_third", 1'b0);

    // Saturation and underflow to zero.
    accept(16'h7FFF, 16'h0001, 1'b1); wait_result("sat_pos", 1'b0);
    accept(16'h8000, 16'h0001, 1'b1); wait_result("sat_neg", 1'b0);
    accept(16'h0001, 16'h7FFF, 1'b1); wait_result("tiny", 1'b0);
    accept(16'hFFFF, 16'h7FFF, 1'b1); wait_result("tiny_neg", 1'b0);
    accept(16'h8000, 16'h1000, 1'b1); wait_result("min_by_one", 1'b0);

    // Divide by zero.
    accept(16'h1000, 16'h0000, 1'b1); wait_result("dz_pos", 1'b0);
    accept(16'hF000, 16'h0000, 1'b1); wait_result("dz_neg", 1'b0);

    // Start pulse during RUN is ignored and not queued.
    accept(16'h2000, 16'h0C00, 1'b1); wait_result("mid_pulse", 1'b1);
    expect_quiet("no_done_after_pulse", 35);

    // start held high: each accept edge takes the operands present at that edge.
    @(negedge clk);
    a = 16'h0800; b = 16'h0400; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(model(16'h0800, 16'h0400));
    chk("b2b_busy0", {31'b0, busy}, 32'd1);
    wait_result("b2b_0", 1'b0);
    a = 16'hD000; b = 16'h0300;
    @(posedge clk);
    #1;
    exp_q.push_back(model(16'hD000, 16'h0300));
    chk("b2b_busy1", {31'b0, busy}, 32'd1);
    wait_result("b2b_1", 1'b0);
    a = 16'h0100; b = 16'hFE00;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back(model(16'h0100, 16'hFE00));
    chk("b2b_busy2", {31'b0, busy}, 32'd1);
    wait_result("b2b_2", 1'b0);

    // Leave nonzero outputs, then reset mid-operation.
    accept(16'hF000, 16'h0000, 1'b1); wait_result("pre_reset", 1'b0);
    accept(16'h3000, 16'h1000, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_c", {16'b0, c}, 32'd0);
    chk("arst_ovf", {31'b0, ovf}, 32'd0);
    chk("arst_dz", {31'b0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_quiet("no_done_after_reset", 35);
    accept(16'h3000, 16'h1000, 1'b1); wait_result("post_reset", 1'b0);

    chk("busy_done_overlap", {31'b0, overlap}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
